// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART transmit definitions: output mux select codes, control FSM states, parity types.
package uart_tx_ctrl_pkg;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte request in, frame sequencing controls out toward the registered TX output mux.
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output mux_sel, ser_data, par_bit, busy
  );

endinterface

// File: rtl/uart_tx_parity_calc.sv
// Combinational frame parity: XOR-reduce of the data, inverted for odd parity.
module uart_tx_parity_calc
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);

  assign par = (par_typ == PAR_ODD) ? ~(^data) : (^data);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX control: latches a byte on request and sequences start, LSB-first data, optional parity, stop.
// Outputs are Moore-decoded from state, counter and shift register; requests while busy are dropped.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave tx
);

  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_calc;
  logic                  accept;
  logic [1:0]            sel;
  logic                  busy_c;

  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (tx.P_DATA),
    .par_typ (tx.PAR_TYP),
    .par     (par_calc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    sel       = SEL_STOP;
    busy_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx.Data_Valid) begin
          accept    = 1'b1;
          state_nxt = ST_START;
        end
      end
      ST_START: begin
        sel       = SEL_START;
        busy_c    = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        sel    = SEL_DATA;
        busy_c = 1'b1;
        if (cnt == CNT_LAST) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        sel       = SEL_PAR;
        busy_c    = 1'b1;
        state_nxt = ST_STOP;
      end
      ST_STOP: begin
        busy_c    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Counter idles at zero so DATA always starts from bit 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shreg     <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      if (accept) begin
        shreg     <= tx.P_DATA;
        par_en_q  <= tx.PAR_EN;
        par_bit_q <= par_calc;
      end
      if (state == ST_DATA) begin
        shreg <= shreg >> 1;
        cnt   <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign tx.mux_sel  = sel;
  assign tx.busy     = busy_c;
  assign tx.ser_data = shreg[0];
  assign tx.par_bit  = par_bit_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Upstream control stage of the UART transmitter.
- Accepts a parallel byte with a valid strobe, latches it, and sequences the frame: start bit, data bits LSB first, optional parity bit, stop bit.
- Drives the select code, serial data bit and parity bit consumed by the registered TX output multiplexer.
- One frame bit per CLK cycle; baud-rate division is done by the clock source feeding CLK.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal range 5..9).

Ports:
- CLK  input  1  transmit clock; one cycle = one bit period.
- RST  input  1  asynchronous, active-high reset.
- P_DATA  input  DATA_WIDTH  parallel data to transmit.
- Data_Valid  input  1  single-cycle request; sampled only in IDLE.
- PAR_EN  input  1  1 = insert parity bit; sampled with the data.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; sampled with the data.
- mux_sel  output  2  00 start, 01 stop/idle, 10 data, 11 parity.
- ser_data  output  1  current data bit, valid while mux_sel=10.
- par_bit  output  1  parity of the latched data, valid while mux_sel=11.
- busy  output  1  high from the cycle after accept through the STOP cycle.

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous, active-high.
- Reset values: state=IDLE, mux_sel=01, ser_data=0, par_bit=0, busy=0; shift register, bit counter and latched config all cleared.
- Output timing: all outputs decode from registered state, counter and shift register only (Moore). No combinational path from any input to any output.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - mux_sel=01, busy=0.
  - If Data_Valid=1 at a rising edge: latch P_DATA, PAR_EN and PAR_TYP; compute par_bit (even: XOR-reduce of data; odd: its inverse); go to START.
- START: one cycle, mux_sel=00, busy=1 → DATA with bit counter=0.
- DATA:
  - DATA_WIDTH cycles, mux_sel=10; ser_data = shift register bit 0, shifted right each cycle (LSB first).
  - On counter = DATA_WIDTH-1: → PARITY if latched PAR_EN=1, else → STOP.
- PARITY: one cycle, mux_sel=11 → STOP.
- STOP: one cycle, mux_sel=01, busy=1 → IDLE.
- Frame length: 1+DATA_WIDTH+PAR_EN+1 cycles of busy=1. At least one IDLE cycle separates back-to-back frames; minimum accept-to-accept spacing = frame length + 1.
- Data_Valid while busy=1: ignored, no queuing, no effect on the frame in flight. Changes on P_DATA, PAR_EN and PAR_TYP mid-frame: no effect.
- Data_Valid held high continuously: a new frame is accepted on every IDLE cycle, i.e. once per frame+1 cycles.
- Reset mid-frame: immediate return to reset values. The partial frame is abandoned and never resumes; the next frame requires a fresh Data_Valid after RST deasserts.
- Counter width: $clog2(DATA_WIDTH). No wrap beyond DATA_WIDTH-1.
- Downstream mux registers again, so the line lags mux_sel by exactly one cycle. This is accounted for at the system level, not compensated here.

Decomposition:
- Shared UART package holds:
  - mux_sel encodings: SEL_START=2'b00, SEL_STOP=2'b01, SEL_DATA=2'b10, SEL_PAR=2'b11.
  - State enum for IDLE/START/DATA/PARITY/STOP.
  - PAR_EVEN/PAR_ODD constants.
- One sub-module: uart_tx_parity_calc (combinational XOR reduce plus type select, DATA_WIDTH-parameterised), instantiated once and registered at accept.
- FSM, counter and serializer stay in this module.

Test Plan:
- Reset: RST=1 mid-DATA (counter=3) → next cycle mux_sel=01, busy=0. No frame output after release until a new Data_Valid.
- Even parity: P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid → mux_sel 00; then 10×8 with ser_data 1,0,1,0,0,1,0,1; then 11 with par_bit=0; then 01. busy high exactly 11 cycles.
- Odd parity: P_DATA=0x01, PAR_EN=1, PAR_TYP=1 → ser_data 1,0,0,0,0,0,0,0; par_bit=0. Repeat with 0x00 → par_bit=1.
- No parity: P_DATA=0xFF, PAR_EN=0 → sequence 00, 10×8 (all ser_data=1), 01. mux_sel never 11. busy high 10 cycles.
- Ignored request: second Data_Valid with P_DATA=0x3C during the DATA state of a 0xA5 frame → first frame unchanged, 0x3C never transmitted.
- Back-to-back: Data_Valid held high with 0x55 then 0xAA, PAR_EN=0 → two frames separated by exactly one IDLE cycle (mux_sel=01, busy=0). Second frame carries 0xAA only if P_DATA=0xAA at that IDLE edge.
